// File: rtl/pam_frame_syn.sv
// pam_frame_syn: preamble-correlating frame synchroniser for the PAM receiver.
// Samples are hard-sliced and slid against the M_SEQ preamble. A match count at
// or above threshold locks the block, which then forwards LENGTH_DATA payload
// samples through a single ready/valid output register and flags the last one.
// Optional feature macro: SYN_POLARITY_INV_EN (lock on a polarity-inverted
// preamble and un-invert the following payload).
module pam_frame_syn #(
  parameter int                         AD_CVER_WIDTH = 12,
  parameter int                         LENTGRH_M_SEQ = 31,
  parameter logic [LENTGRH_M_SEQ-1:0]   M_SEQ         = 31'h2EC7_CD21,
  parameter int                         WIDTH_RESULT  = 6,
  parameter int                         THRESHOLD     = 25,
  parameter int                         LENGTH_DATA   = 32
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [AD_CVER_WIDTH-1:0] S_AXIS_tdata,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  input  logic [WIDTH_RESULT-1:0]  cfg_threshold,
  output logic [AD_CVER_WIDTH-1:0] syn_demodu_data,
  output logic                     syn_demodu_valid,
  input  logic                     syn_demodu_ready,
  output logic                     syn_demodu_last,
  output logic                     syn_locked,
  output logic                     syn_inverted,
  output logic [WIDTH_RESULT-1:0]  syn_peak,
  output logic [15:0]              syn_frame_cnt
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCK   = 1'b1;

  localparam int                      CW       = (LENGTH_DATA > 1) ? $clog2(LENGTH_DATA) : 1;
  localparam logic [CW-1:0]           LAST_IDX = CW'(LENGTH_DATA - 1);
  localparam logic [WIDTH_RESULT-1:0] THR_DEF  = WIDTH_RESULT'(THRESHOLD);
  localparam logic [WIDTH_RESULT:0]   SEQ_LEN  = (WIDTH_RESULT + 1)'(LENTGRH_M_SEQ);

  // Number of set bits in a window-wide vector.
  function automatic logic [WIDTH_RESULT-1:0] popcount(input logic [LENTGRH_M_SEQ-1:0] vec);
    logic [WIDTH_RESULT-1:0] acc;
    acc = {WIDTH_RESULT{1'b0}};
    for (int i = 0; i < LENTGRH_M_SEQ; i++) begin
      acc = acc + {{(WIDTH_RESULT-1){1'b0}}, vec[i]};
    end
    return acc;
  endfunction

  logic [0:0]                    state_r;
  // Only bits L-1..1 of the window are ever read again: bit 0 is the oldest
  // sample and falls out on the next shift, so it is not stored.
  logic [LENTGRH_M_SEQ-1:1]      win_r;
  logic [CW-1:0]                 cnt_r;

  logic                          slice_bit;
  logic [LENTGRH_M_SEQ-1:0]      next_win;
  logic [WIDTH_RESULT-1:0]       match;
  logic [WIDTH_RESULT-1:0]       thr;
  logic                          hit_norm;
  logic                          accept;
  logic                          last_now;
  logic [AD_CVER_WIDTH-1:0]      payload;

  assign slice_bit = S_AXIS_tdata[AD_CVER_WIDTH-1];
  assign next_win  = {slice_bit, win_r};
  assign match     = popcount(~(next_win ^ M_SEQ));
  assign thr       = (cfg_threshold == {WIDTH_RESULT{1'b0}}) ? THR_DEF : cfg_threshold;
  assign hit_norm  = (match >= thr);
  assign last_now  = (cnt_r == LAST_IDX);

  // SEARCH always accepts; LOCK accepts only when the output register can take a beat.
  assign S_AXIS_tready = (state_r == SEARCH) ? 1'b1 : (!syn_demodu_valid || syn_demodu_ready);
  assign accept        = S_AXIS_tvalid && S_AXIS_tready;

`ifdef SYN_POLARITY_INV_EN
  logic hit_inv;
  // m <= L - thr, rearranged to m + thr <= L so no negative intermediate exists.
  assign hit_inv = !hit_norm && (({1'b0, match} + {1'b0, thr}) <= SEQ_LEN);
  assign payload = syn_inverted ? ~S_AXIS_tdata : S_AXIS_tdata;
`else
  assign payload      = S_AXIS_tdata;
  assign syn_inverted = 1'b0;
`endif

  // Output register, window/counter state, status outputs and the SEARCH/LOCK FSM.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r          <= SEARCH;
      win_r            <= {(LENTGRH_M_SEQ-1){1'b0}};
      cnt_r            <= {CW{1'b0}};
      syn_demodu_data  <= {AD_CVER_WIDTH{1'b0}};
      syn_demodu_valid <= 1'b0;
      syn_demodu_last  <= 1'b0;
      syn_locked       <= 1'b0;
      syn_peak         <= {WIDTH_RESULT{1'b0}};
      syn_frame_cnt    <= 16'd0;
`ifdef SYN_POLARITY_INV_EN
      syn_inverted     <= 1'b0;
`endif
    end else begin
      if (accept && (state_r == LOCK)) begin
        syn_demodu_data  <= payload;
        syn_demodu_valid <= 1'b1;
        syn_demodu_last  <= last_now;
      end else if (syn_demodu_ready) begin
        syn_demodu_valid <= 1'b0;
      end

      case (state_r)
        SEARCH: begin
          if (accept) begin
            if (hit_norm) begin
              state_r      <= LOCK;
              syn_locked   <= 1'b1;
              syn_peak     <= match;
              cnt_r        <= {CW{1'b0}};
              win_r        <= {(LENTGRH_M_SEQ-1){1'b0}};
`ifdef SYN_POLARITY_INV_EN
              syn_inverted <= 1'b0;
            end else if (hit_inv) begin
              state_r      <= LOCK;
              syn_locked   <= 1'b1;
              syn_peak     <= match;
              cnt_r        <= {CW{1'b0}};
              win_r        <= {(LENTGRH_M_SEQ-1){1'b0}};
              syn_inverted <= 1'b1;
`endif
            end else begin
              win_r <= next_win[LENTGRH_M_SEQ-1:1];
            end
          end
        end
        LOCK: begin
          if (accept) begin
            if (last_now) begin
              state_r       <= SEARCH;
              syn_locked    <= 1'b0;
              cnt_r         <= {CW{1'b0}};
              syn_frame_cnt <= syn_frame_cnt + 16'd1;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        default: begin
          state_r    <= SEARCH;
          syn_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pam_frame_syn.sv
// Randomised/directed bench for pam_frame_syn with a queue-based reference
// model and a decoupled payload scoreboard monitor.
module tb_pam_frame_syn;

  localparam int          W    = 12;
  localparam int          L    = 31;
  localparam int          LEN  = 32;
  localparam logic [30:0] MSEQ = 31'h2EC7_CD21;

  logic          clk;
  logic          arst_n;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [5:0]    cfg_threshold;
  logic [W-1:0]  dm_data;
  logic          dm_valid;
  logic          dm_ready;
  logic          dm_last;
  logic          locked;
  logic          inverted;
  logic [5:0]    peak;
  logic [15:0]   frame_cnt;

  pam_frame_syn dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .S_AXIS_tdata     (s_tdata),
    .S_AXIS_tvalid    (s_tvalid),
    .S_AXIS_tready    (s_tready),
    .cfg_threshold    (cfg_threshold),
    .syn_demodu_data  (dm_data),
    .syn_demodu_valid (dm_valid),
    .syn_demodu_ready (dm_ready),
    .syn_demodu_last  (dm_last),
    .syn_locked       (locked),
    .syn_inverted     (inverted),
    .syn_peak         (peak),
    .syn_frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  // Reference model state
  logic [12:0] exp_q[$];
  bit          hist[$];      // hist[0] is the oldest sliced bit
  logic        m_locked;
  logic        m_inv;
  logic [5:0]  m_peak;
  int          m_cnt;
  logic [15:0] m_frames;
  logic        m_out_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < L; i++) hist.push_back(1'b0);
    exp_q.delete();
    m_locked    = 1'b0;
    m_inv       = 1'b0;
    m_peak      = 6'd0;
    m_cnt       = 0;
    m_frames    = 16'd0;
    m_out_valid = 1'b0;
  endtask

  task automatic model_lock(input int m, input logic inv);
    m_locked = 1'b1;
    m_peak   = 6'(m);
    m_inv    = inv;
    m_cnt    = 0;
    for (int i = 0; i < L; i++) hist[i] = 1'b0;
  endtask

  // One clock cycle: apply inputs, compare status with the model, then advance the model.
  task automatic drive(input logic [W-1:0] d, input logic v, input logic r, output logic acc);
    logic exp_tready;
    logic was_locked;
    logic is_last;
    int   m;
    int   thr;
    @(posedge clk);
    #1;
    s_tdata  = d;
    s_tvalid = v;
    dm_ready = r;
    @(negedge clk);
    chk("locked", 32'(locked), 32'(m_locked));
    chk("inverted", 32'(inverted), 32'(m_inv));
    chk("peak", 32'(peak), 32'(m_peak));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("out_valid", 32'(dm_valid), 32'(m_out_valid));
    exp_tready = !m_locked || !m_out_valid || r;
    chk("tready", 32'(s_tready), 32'(exp_tready));
    acc        = v && exp_tready;
    was_locked = m_locked;
    if (acc && was_locked) begin
      is_last = (m_cnt == LEN - 1);
      exp_q.push_back({is_last, (m_inv ? ~d : d)});
      m_out_valid = 1'b1;
      if (is_last) begin
        m_locked = 1'b0;
        m_frames = m_frames + 16'd1;
        m_cnt    = 0;
      end else begin
        m_cnt++;
      end
    end else if (r) begin
      m_out_valid = 1'b0;
    end
    if (acc && !was_locked) begin
      hist.push_back(d[W-1]);
      void'(hist.pop_front());
      m = 0;
      for (int i = 0; i < L; i++) if (hist[i] == MSEQ[i]) m++;
      thr = (cfg_threshold == 6'd0) ? 25 : int'(cfg_threshold);
      if (m >= thr) model_lock(m, 1'b0);
`ifdef SYN_POLARITY_INV_EN
      else if (m + thr <= L) model_lock(m, 1'b1);
`endif
    end
  endtask

  // Payload scoreboard: pops on every transfer and checks hold-stability under backpressure.
  logic        held_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (!arst_n) begin
      held_prev = 1'b0;
    end else begin
      if (locked && dm_valid && !dm_ready) chk("tready_bp", 32'(s_tready), 32'd0);
      if (held_prev) begin
        chk("hold_data", 32'(dm_data), 32'(prev_data));
        chk("hold_last", 32'(dm_last), 32'(prev_last));
      end
      if (dm_valid && dm_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected_valid", 32'(dm_valid), 32'd0);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          chk("out_data", 32'(dm_data), 32'(e[11:0]));
          chk("out_last", 32'(dm_last), 32'(e[12]));
          n_out++;
        end
      end
      held_prev = dm_valid && !dm_ready;
      prev_data = dm_data;
      prev_last = dm_last;
    end
  end

  task automatic chk_zero();
    chk("rst_valid", 32'(dm_valid), 32'd0);
    chk("rst_last", 32'(dm_last), 32'd0);
    chk("rst_data", 32'(dm_data), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_inverted", 32'(inverted), 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);
  endtask

  task automatic send_pre(input logic [30:0] pat);
    logic acc;
    for (int i = 0; i < L; i++) drive(pat[i] ? 12'hC00 : 12'h400, 1'b1, 1'b1, acc);
    drive(12'h000, 1'b0, 1'b1, acc);   // idle cycle: lock edge now visible
  endtask

  task automatic send_payload(input logic [W-1:0] base, input logic bp);
    int   idx = 0;
    int   g   = 0;
    logic acc;
    logic r;
    while (idx < LEN && g < 400) begin
      r = bp ? logic'(g % 2 == 0) : 1'b1;
      drive(base + 12'(idx), 1'b1, r, acc);
      if (acc) idx++;
      g++;
    end
    if (idx < LEN) chk("payload_timeout", 32'(idx), 32'(LEN));
    drive(12'h000, 1'b0, 1'b1, acc);
    drive(12'h000, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   g;
    int   f0;
    int   o0;
    arst_n        = 1'b0;
    s_tdata       = 12'h000;
    s_tvalid      = 1'b0;
    dm_ready      = 1'b0;
    cfg_threshold = 6'd0;
    model_reset();
    #12;
    chk_zero();
    @(negedge clk);
    arst_n = 1'b1;

    // Random traffic: model predicts any (unlikely) lock
    for (int i = 0; i < 100; i++)
      drive(12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    g = 0;
    while (m_locked && g < 300) begin
      drive(12'($urandom), 1'b1, 1'b1, acc);
      g++;
    end
    drive(12'h000, 1'b0, 1'b1, acc);
    drive(12'h000, 1'b0, 1'b1, acc);

    // Clean preamble and frame
    f0 = int'(m_frames);
    o0 = n_out;
    send_pre(MSEQ);
    chk("clean_locked", 32'(locked), 32'd1);
    chk("clean_peak", 32'(peak), 32'd31);
    send_payload(12'h000, 1'b0);
    chk("clean_frames", 32'(frame_cnt), 32'(f0 + 1));
    chk("clean_unlocked", 32'(locked), 32'd0);
    chk("clean_outs", 32'(n_out - o0), 32'd32);

    // Threshold edge
    send_pre(MSEQ ^ 31'h0000_003F);
    chk("thr25_locked", 32'(locked), 32'd1);
    chk("thr25_peak", 32'(peak), 32'd25);
    send_payload(12'h100, 1'b0);
    send_pre(MSEQ ^ 31'h0000_007F);
    chk("thr24_nolock", 32'(locked), 32'd0);
    cfg_threshold = 6'd24;
    send_pre(MSEQ ^ 31'h0000_007F);
    chk("cfg24_locked", 32'(locked), 32'd1);
    chk("cfg24_peak", 32'(peak), 32'd24);
    send_payload(12'h200, 1'b0);
    cfg_threshold = 6'd0;

    // Backpressure
    o0 = n_out;
    send_pre(MSEQ);
    chk("bp_locked", 32'(locked), 32'd1);
    send_payload(12'h300, 1'b1);
    chk("bp_outs", 32'(n_out - o0), 32'd32);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Inverted preamble
    send_pre(~MSEQ);
`ifdef SYN_POLARITY_INV_EN
    chk("inv_locked", 32'(locked), 32'd1);
    chk("inv_flag", 32'(inverted), 32'd1);
    chk("inv_peak", 32'(peak), 32'd0);
    send_payload(12'h000, 1'b0);
`else
    chk("inv_nolock", 32'(locked), 32'd0);
`endif

    // Reset in the middle of a frame
    send_pre(MSEQ);
    for (int i = 0; i < 10; i++) drive(12'(i), 1'b1, 1'b1, acc);
    @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    chk_zero();
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    send_pre(MSEQ);
    chk("post_rst_locked", 32'(locked), 32'd1);
    send_payload(12'h040, 1'b0);
    chk("post_rst_frames", 32'(frame_cnt), 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
